// File: rtl/fwd_operand_stage.sv
// EX-stage operand forwarding mux with a registered output, stall/flush and a forwarding counter.
// Optional sticky out-of-range select flag is built when FWD_SEL_CHECK_EN is defined.
module fwd_operand_stage #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_SRC*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]         sel_i,
    input  logic [WIDTH-1:0]         imm_i,
    input  logic                     use_imm_i,
    input  logic                     valid_i,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic                     cnt_clr_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic [CNT_W-1:0]         fwd_cnt_o,
    output logic                     sel_err_o
);

    logic [WIDTH-1:0] pick;
    logic             fwd_sel_hit;
    logic             load;
    logic             fwd_event;

    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Out-of-range selects fall back to the register-file value (source 0).
    always_comb begin
        pick        = data_i[0 +: WIDTH];
        fwd_sel_hit = 1'b0;
        for (int k = 1; k < NUM_SRC; k++) begin
            if (sel_i == SEL_W'(k)) begin
                pick        = data_i[k*WIDTH +: WIDTH];
                fwd_sel_hit = 1'b1;
            end
        end
        if (use_imm_i) begin
            pick = imm_i;
        end
    end

    assign load      = !flush_i && !stall_i;
    assign fwd_event = load && valid_i && !use_imm_i && fwd_sel_hit;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            data_d  = '0;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            data_d  = pick;
            valid_d = valid_i;
        end
        // Clear beats a simultaneous increment; the count sticks at all-ones.
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (fwd_event && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FWD_SEL_CHECK_EN
    logic sel_oor;
    logic sel_err_d, sel_err_q;

    assign sel_oor = (32'(sel_i) >= 32'(NUM_SRC));

    // Sticky until reset; the counter clear deliberately leaves it alone.
    always_comb begin
        sel_err_d = sel_err_q;
        if (load && valid_i && !use_imm_i && sel_oor) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err_o = sel_err_q;
`else
    assign sel_err_o = 1'b0;
`endif

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign fwd_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Directed plus randomized bench for fwd_operand_stage (NUM_SRC=3, CNT_W=4) against a
// cycle-level reference model built from the selection/stall/flush/count rules.
module tb_fwd_operand_stage;

    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 3;
    localparam int SEL_W   = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                     clk_i;
    logic                     rst_i;
    logic [NUM_SRC*WIDTH-1:0] data_i;
    logic [SEL_W-1:0]         sel_i;
    logic [WIDTH-1:0]         imm_i;
    logic                     use_imm_i;
    logic                     valid_i;
    logic                     stall_i;
    logic                     flush_i;
    logic                     cnt_clr_i;
    logic [WIDTH-1:0]         data_o;
    logic                     valid_o;
    logic [CNT_W-1:0]         fwd_cnt_o;
    logic                     sel_err_o;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] src [NUM_SRC];
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_known;
    int               m_cnt;
    logic             m_err;

    fwd_operand_stage #(
        .WIDTH  (WIDTH),
        .NUM_SRC(NUM_SRC),
        .SEL_W  (SEL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .sel_i    (sel_i),
        .imm_i    (imm_i),
        .use_imm_i(use_imm_i),
        .valid_i  (valid_i),
        .stall_i  (stall_i),
        .flush_i  (flush_i),
        .cnt_clr_i(cnt_clr_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .fwd_cnt_o(fwd_cnt_o),
        .sel_err_o(sel_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_data  = '0;
        m_valid = 1'b0;
        m_known = 1'b1;
        m_cnt   = 0;
        m_err   = 1'b0;
    endtask

    task automatic check_all(input string tag);
        if (m_known) check_val({tag, ".data"}, data_o, m_data);
        check_val({tag, ".valid"}, 32'(valid_o), 32'(m_valid));
        check_val({tag, ".cnt"}, 32'(fwd_cnt_o), 32'(m_cnt));
        check_val({tag, ".err"}, 32'(sel_err_o), 32'(m_err));
    endtask

    task automatic set_srcs(input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] s1,
                            input logic [WIDTH-1:0] s2);
        src[0] = s0;
        src[1] = s1;
        src[2] = s2;
    endtask

    // One clock: drive on the falling edge, advance the model, sample 1 ns after the rising edge.
    task automatic step(input string tag, input int sel, input logic uimm, input logic [WIDTH-1:0] imm,
                        input logic vld, input logic stl, input logic fls, input logic clr);
        logic [WIDTH-1:0] pick;
        logic             is_load;
        @(negedge clk_i);
        for (int k = 0; k < NUM_SRC; k++) data_i[k*WIDTH +: WIDTH] = src[k];
        sel_i     = SEL_W'(sel);
        use_imm_i = uimm;
        imm_i     = imm;
        valid_i   = vld;
        stall_i   = stl;
        flush_i   = fls;
        cnt_clr_i = clr;

        if (uimm)              pick = imm;
        else if (sel < NUM_SRC) pick = src[sel];
        else                   pick = src[0];
        is_load = !fls && !stl;

        if (clr) m_cnt = 0;
        else if (is_load && vld && !uimm && sel > 0 && sel < NUM_SRC && m_cnt < CNT_MAX) m_cnt++;
`ifdef FWD_SEL_CHECK_EN
        if (is_load && vld && !uimm && sel >= NUM_SRC) m_err = 1'b1;
`endif
        if (fls) begin
            m_data  = '0;
            m_valid = 1'b0;
            m_known = 1'b1;
        end else if (!stl) begin
            m_data  = pick;
            m_valid = vld;
            m_known = vld;
        end

        @(posedge clk_i);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_i     = 1'b1;
        data_i    = '0;
        sel_i     = '0;
        imm_i     = '0;
        use_imm_i = 1'b0;
        valid_i   = 1'b0;
        stall_i   = 1'b0;
        flush_i   = 1'b0;
        cnt_clr_i = 1'b0;
        set_srcs(32'h1000_0000, 32'h1000_0001, 32'h1000_0002);
        model_reset();

        repeat (2) @(posedge clk_i);
        #1;
        check_all("reset_hold");
        @(negedge clk_i);
        rst_i = 1'b0;

        step("sel2",      2, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0);
        step("imm",       2, 1'b1, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("sel0",      0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0);

        set_srcs(32'h0, 32'hA5A5_A5A5, 32'h0);
        step("load_a5",   1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0);
        set_srcs(32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        for (int i = 0; i < 3; i++)
            step("stall",  1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0);
        step("stall_flush", 1, 1'b0, 32'h0,       1'b1, 1'b1, 1'b1, 1'b0);
        step("flush",     2, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0);

        step("bubble",    1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0);
        step("range",     3, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0);
        step("range_imm", 3, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++)
            step("sat",    1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0);
        check_val("sat_value", 32'(fwd_cnt_o), 32'd15);
        step("clr_wins",  1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1);
        check_val("clr_value", 32'(fwd_cnt_o), 32'd0);
        step("after_clr", 2, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            set_srcs($urandom, $urandom, $urandom);
            step("rand", int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), $urandom,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset in the middle of a stall, between clock edges.
        set_srcs(32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002);
        step("pre_rst",   1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0);
        step("pre_rst_st", 3, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk_i);
        rst_i = 1'b0;
        step("post_rst",  2, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
